// File: rtl/layer_writeback.sv
// layer_writeback: activation, result buffering and SRAM write-back for one layer round.
// Sums from the layer datapath are range-checked against the round's neuron count. They
// are activated, queued in a small FIFO and written to the activation SRAM at a
// round-dependent base address. A one-cycle layer_done pulse marks the round's last write.
// Optional feature: define ACT_RELU_EN to apply ReLU. Without it the activation is identity.
module layer_writeback #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OUT_N0     = 6,
    parameter int unsigned OUT_N1     = 3,
    parameter int unsigned BASE0      = 0,
    parameter int unsigned BASE1      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        round,
    input  logic              sum_valid,
    output logic              sum_ready,
    input  logic [DATA_W-1:0] sum_data,
    input  logic [ADDR_W-1:0] sum_idx,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_ack,
    output logic              layer_done,
    output logic [ADDR_W-1:0] wr_count,
    output logic              err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              rnd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_n;
    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              accept, in_range, push, pop;
    logic              load_head, load_next, wr_inc, wr_clr;
    logic              cur_rnd;
    logic [DATA_W-1:0] act_data;
    logic [ADDR_W-1:0] base_addr, push_addr, wr_count_inc, target;
    entry_t            push_entry;

    assign accept     = sum_valid && sum_ready;
    assign push       = accept && in_range;
    assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

    // Neuron index range check for the round presented with the transfer
    always_comb begin
        in_range = 1'b0;
        case (round)
            2'd0:    in_range = (32'(sum_idx) < OUT_N0);
            2'd1:    in_range = (32'(sum_idx) < OUT_N1);
            default: in_range = 1'b0;
        endcase
    end

    // Activation and address formation for the entry being pushed
    always_comb begin
`ifdef ACT_RELU_EN
        act_data = sum_data[DATA_W-1] ? '0 : sum_data;
`else
        act_data = sum_data;
`endif
        base_addr       = round[0] ? ADDR_W'(BASE1) : ADDR_W'(BASE0);
        push_addr       = base_addr + sum_idx;
        push_entry.rnd  = round[0];
        push_entry.addr = push_addr;
        push_entry.data = act_data;
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        cnt_n = cnt;
        if (push && !pop) begin
            cnt_n = cnt + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_n = cnt - CNT_W'(1);
        end
    end

    // FIFO storage (datapath only, no reset needed)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            sum_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            cnt       <= cnt_n;
            sum_ready <= (cnt_n != CNT_W'(FIFO_DEPTH));
        end
    end

    // Sticky error on out-of-range or invalid-round transfers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (accept && !in_range) begin
            err <= 1'b1;
        end
    end

    assign wr_count_inc = wr_count + ADDR_W'(1);
    assign target       = cur_rnd ? ADDR_W'(OUT_N1) : ADDR_W'(OUT_N0);

    // Write FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Write FSM next-state and control
    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        load_head = 1'b0;
        load_next = 1'b0;
        wr_inc    = 1'b0;
        wr_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (cnt != '0) begin
                    load_head = 1'b1;
                    state_n   = WRITE;
                end
            end
            WRITE: begin
                if (sram_ack) begin
                    pop    = 1'b1;
                    wr_inc = 1'b1;
                    if (wr_count_inc == target) begin
                        state_n = DONE;
                    end else if (cnt > CNT_W'(1)) begin
                        load_next = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DONE: begin
                wr_clr  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered SRAM request, write payload, done pulse and write counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            cur_rnd    <= 1'b0;
            layer_done <= 1'b0;
            wr_count   <= '0;
        end else begin
            sram_we    <= (state_n == WRITE);
            layer_done <= (state_n == DONE);
            if (load_head) begin
                sram_addr  <= mem[rd_ptr].addr;
                sram_wdata <= mem[rd_ptr].data;
                cur_rnd    <= mem[rd_ptr].rnd;
            end else if (load_next) begin
                sram_addr  <= mem[rd_ptr_nxt].addr;
                sram_wdata <= mem[rd_ptr_nxt].data;
                cur_rnd    <= mem[rd_ptr_nxt].rnd;
            end
            if (wr_clr) begin
                wr_count <= '0;
            end else if (wr_inc) begin
                wr_count <= wr_count_inc;
            end
        end
    end

endmodule

// File: tb/tb_layer_writeback.sv
// Directed bench for layer_writeback: full rounds, backpressure, ReLU/identity data,
// range errors, mid-write reset and simultaneous push/pop.
module tb_layer_writeback;

    logic        clk;
    logic        rst;
    logic [1:0]  round;
    logic        sum_valid;
    logic        sum_ready;
    logic [15:0] sum_data;
    logic [3:0]  sum_idx;
    logic        sram_we;
    logic [3:0]  sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_ack;
    logic        layer_done;
    logic [3:0]  wr_count;
    logic        err;

    int total;
    int passed;

    layer_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .round      (round),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sum_data   (sum_data),
        .sum_idx    (sum_idx),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_ack   (sram_ack),
        .layer_done (layer_done),
        .wr_count   (wr_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        sum_valid = 1'b0;
        sram_ack  = 1'b0;
        round     = 2'd0;
        sum_idx   = '0;
        sum_data  = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    logic [15:0] exp_neg;

    initial begin
        total  = 0;
        passed = 0;
`ifdef ACT_RELU_EN
        exp_neg = 16'h0000;
`else
        exp_neg = 16'h8005;
`endif

        // Reset values
        rst = 1'b0; sum_valid = 1'b0; sram_ack = 1'b0; round = 2'd0;
        sum_idx = '0; sum_data = '0;
        tick();
        check("rst_ready", 32'(sum_ready), 32'd1);
        check("rst_we", 32'(sram_we), 32'd0);
        check("rst_done", 32'(layer_done), 32'd0);
        check("rst_wrcnt", 32'(wr_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        rst = 1'b1;
        tick();

        // Round 0: six pushes with ack held high
        sram_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sum_valid = 1'b1;
            sum_idx   = 4'(k);
            sum_data  = 16'((k + 1) * 100);
            tick();
            if (k == 0) begin
                check("t1_we_first", 32'(sram_we), 32'd0);
            end else begin
                check("t1_we", 32'(sram_we), 32'd1);
                check("t1_addr", 32'(sram_addr), 32'(k - 1));
                check("t1_data", 32'(sram_wdata), 32'(k * 100));
                check("t1_wrcnt", 32'(wr_count), 32'(k - 1));
            end
        end
        sum_valid = 1'b0;
        tick();
        check("t1_we6", 32'(sram_we), 32'd1);
        check("t1_addr6", 32'(sram_addr), 32'd5);
        check("t1_data6", 32'(sram_wdata), 32'd600);
        check("t1_done_early", 32'(layer_done), 32'd0);
        tick();
        check("t1_done", 32'(layer_done), 32'd1);
        check("t1_we_done", 32'(sram_we), 32'd0);
        check("t1_wrcnt6", 32'(wr_count), 32'd6);
        tick();
        check("t1_done_pulse", 32'(layer_done), 32'd0);
        check("t1_wrcnt_clr", 32'(wr_count), 32'd0);
        check("t1_we_idle", 32'(sram_we), 32'd0);

        // Backpressure: ack low, five back-to-back transfers
        do_reset();
        for (int k = 0; k < 5; k++) begin
            sum_valid = 1'b1;
            sum_idx   = 4'(k);
            sum_data  = 16'h0A00 + 16'(k);
            tick();
            if (k == 2) check("t2_ready_3", 32'(sum_ready), 32'd1);
            if (k == 3) check("t2_ready_full", 32'(sum_ready), 32'd0);
        end
        check("t2_ready_held", 32'(sum_ready), 32'd0);
        check("t2_hold_addr", 32'(sram_addr), 32'd0);
        check("t2_hold_we", 32'(sram_we), 32'd1);
        sram_ack = 1'b1;
        tick();
        check("t2_ready_back", 32'(sum_ready), 32'd1);
        check("t2_addr1", 32'(sram_addr), 32'd1);
        tick();
        sum_valid = 1'b0;
        check("t2_addr2", 32'(sram_addr), 32'd2);
        check("t2_ready_pp", 32'(sum_ready), 32'd1);
        tick();
        check("t2_addr3", 32'(sram_addr), 32'd3);
        check("t2_data3", 32'(sram_wdata), 32'h0A03);
        tick();
        check("t2_addr4", 32'(sram_addr), 32'd4);
        check("t2_data4", 32'(sram_wdata), 32'h0A04);
        check("t2_we4", 32'(sram_we), 32'd1);
        tick();
        check("t2_we_end", 32'(sram_we), 32'd0);
        check("t2_wrcnt5", 32'(wr_count), 32'd5);
        check("t2_no_done", 32'(layer_done), 32'd0);

        // Simultaneous accept and ack with three entries queued
        do_reset();
        for (int k = 0; k < 3; k++) begin
            sum_valid = 1'b1;
            sum_idx   = 4'(k);
            sum_data  = 16'h0B00 + 16'(k);
            tick();
        end
        check("t6_we", 32'(sram_we), 32'd1);
        check("t6_addr0", 32'(sram_addr), 32'd0);
        sum_idx = 4'd3; sum_data = 16'h0B03; sram_ack = 1'b1;
        tick();
        check("t6_ready_pp", 32'(sum_ready), 32'd1);
        check("t6_addr1", 32'(sram_addr), 32'd1);
        sum_idx = 4'd4; sum_data = 16'h0B04; sram_ack = 1'b0;
        tick();
        check("t6_ready_full", 32'(sum_ready), 32'd0);
        sum_valid = 1'b0; sram_ack = 1'b1;
        tick();
        check("t6_ready_ret", 32'(sum_ready), 32'd1);
        check("t6_addr2", 32'(sram_addr), 32'd2);
        tick();
        check("t6_addr3", 32'(sram_addr), 32'd3);
        check("t6_data3", 32'(sram_wdata), 32'h0B03);
        tick();
        check("t6_addr4", 32'(sram_addr), 32'd4);
        check("t6_data4", 32'(sram_wdata), 32'h0B04);
        tick();
        check("t6_we_end", 32'(sram_we), 32'd0);
        check("t6_wrcnt5", 32'(wr_count), 32'd5);

        // Round 1: base address 8 and activation of a negative sum
        do_reset();
        round = 2'd1; sram_ack = 1'b1; sum_valid = 1'b1;
        sum_idx = 4'd0; sum_data = 16'h8005;
        tick();
        sum_idx = 4'd1; sum_data = 16'h0007;
        tick();
        check("t3_addr8", 32'(sram_addr), 32'd8);
        check("t3_data8", 32'(sram_wdata), 32'(exp_neg));
        sum_idx = 4'd2; sum_data = 16'h7FFF;
        tick();
        sum_valid = 1'b0;
        check("t3_addr9", 32'(sram_addr), 32'd9);
        check("t3_data9", 32'(sram_wdata), 32'h0007);
        tick();
        check("t3_addr10", 32'(sram_addr), 32'd10);
        check("t3_data10", 32'(sram_wdata), 32'h7FFF);
        check("t3_done_early", 32'(layer_done), 32'd0);
        tick();
        check("t3_done", 32'(layer_done), 32'd1);
        check("t3_wrcnt3", 32'(wr_count), 32'd3);
        tick();
        check("t3_done_pulse", 32'(layer_done), 32'd0);
        check("t3_wrcnt_clr", 32'(wr_count), 32'd0);

        // Invalid transfers: consumed, never written, sticky err
        do_reset();
        sram_ack = 1'b1; sum_valid = 1'b1;
        round = 2'd1; sum_idx = 4'd3; sum_data = 16'h1234;
        check("t4_ready_a", 32'(sum_ready), 32'd1);
        tick();
        check("t4_err_a", 32'(err), 32'd1);
        round = 2'd2; sum_idx = 4'd0; sum_data = 16'h5678;
        check("t4_ready_b", 32'(sum_ready), 32'd1);
        tick();
        sum_valid = 1'b0;
        check("t4_err_b", 32'(err), 32'd1);
        check("t4_ready_after", 32'(sum_ready), 32'd1);
        tick();
        check("t4_no_we1", 32'(sram_we), 32'd0);
        tick();
        check("t4_no_we2", 32'(sram_we), 32'd0);
        round = 2'd0; sum_idx = 4'd2; sum_data = 16'h0042; sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
        tick();
        check("t4_valid_we", 32'(sram_we), 32'd1);
        check("t4_valid_addr", 32'(sram_addr), 32'd2);
        check("t4_valid_data", 32'(sram_wdata), 32'h0042);
        check("t4_err_sticky", 32'(err), 32'd1);
        tick();
        check("t4_wrcnt1", 32'(wr_count), 32'd1);
        check("t4_err_sticky2", 32'(err), 32'd1);
        rst = 1'b0;
        #1;
        check("t4_err_clr", 32'(err), 32'd0);

        // Reset while writing with three entries queued
        do_reset();
        for (int k = 0; k < 3; k++) begin
            sum_valid = 1'b1;
            sum_idx   = 4'(k);
            sum_data  = 16'h0C00 + 16'(k);
            tick();
        end
        sum_valid = 1'b0;
        tick();
        check("t5_we_before", 32'(sram_we), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_we_async", 32'(sram_we), 32'd0);
        check("t5_ready_rst", 32'(sum_ready), 32'd1);
        tick();
        rst = 1'b1;
        sram_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_we_after", 32'(sram_we), 32'd0);
            check("t5_done_after", 32'(layer_done), 32'd0);
            check("t5_wrcnt_after", 32'(wr_count), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/layer_writeback.md
Name: layer_writeback

Overview:
- Write-side counterpart of the layer sequencer's address/read path.
- Accepts one accumulated sum per output neuron from the layer datapath over a valid/ready handshake.
- Applies the activation, buffers results in a small FIFO and writes them into the activation SRAM at a round-dependent base address.
- Signals layer completion so the sequencer can advance its round.

Parameters:
- DATA_W, 16, width of sums and SRAM write data (two's complement).
- ADDR_W, 4, width of neuron index and SRAM address.
- FIFO_DEPTH, 4, result buffer entries; must be a power of 2, minimum 2.
- OUT_N0, 6, neurons written in round 0.
- OUT_N1, 3, neurons written in round 1.
- BASE0, 0, SRAM base address for round 0 results.
- BASE1, 8, SRAM base address for round 1 results.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- round  in  2  current layer round from the sequencer; sampled at each accepted transfer.
- sum_valid  in  1  sum_data/sum_idx are valid.
- sum_ready  out  1  block can accept a transfer.
- sum_data  in  DATA_W  signed accumulated sum.
- sum_idx  in  ADDR_W  output neuron index (same numbering as OUTaddr).
- sram_we  out  1  write request to the SRAM.
- sram_addr  out  ADDR_W  write address.
- sram_wdata  out  DATA_W  write data.
- sram_ack  in  1  SRAM accepted the write this cycle.
- layer_done  out  1  one-cycle pulse when the round's last neuron is written.
- wr_count  out  ADDR_W  neurons written in the current round.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM in IDLE, wr_count=0, err=0. All outputs 0 except sum_ready.
- sum_ready = !fifo_full. It is a registered function of the FIFO count; there is no full-FIFO bypass.
- Transfer occurs when sum_valid && sum_ready at a clock edge.
- Range check at accept: round 0 requires sum_idx < OUT_N0; round 1 requires sum_idx < OUT_N1; round 2 or 3 is always invalid.
  - Invalid transfers are consumed (handshake completes), not pushed, and set err.
  - err clears only on reset.
- Pushed entry = {act(sum_data), BASE(round)+sum_idx}. Address arithmetic is modulo 2^ADDR_W.
- Activation is purely combinational before the push. No extra latency.
- FIFO: simultaneous push and pop is allowed when not full; count is unchanged.
- Write FSM:
  - IDLE: if FIFO non-empty, load head into output registers and go to WRITE. First write request appears 1 cycle after the push.
  - WRITE: sram_we=1, with addr/wdata held stable. On sram_ack: pop FIFO, wr_count+1.
    - If the new wr_count equals the round target, go to DONE.
    - Else if FIFO still non-empty, load the next entry and stay in WRITE (back-to-back writes, one per ack).
    - Else go to IDLE.
  - DONE: one cycle. layer_done=1, wr_count←0, then IDLE.
- Round target uses the round of the entry just written (stored alongside each FIFO entry).
- sram_we is never asserted in IDLE or DONE. sram_ack outside WRITE is ignored.
- Transfers are accepted during DONE if not full.
- Reset mid-write: the FIFO is discarded and sram_we drops immediately (asynchronously).
- Duplicate indices are not detected; each is written and counted.

Optional Feature:
- Macro ACT_RELU_EN.
- Defined: act(x) = 0 if x is negative (MSB=1), else x.
- Undefined: act(x) = x (identity). No other behaviour changes.

Test Plan:
- Reset then round=0, push idx 0..5 with data 100,200,…,600, sram_ack held high → writes to addr 0..5 with matching data on 6 consecutive cycles, one layer_done pulse after the 6th write, wr_count returns to 0.
- sram_ack held low, push 5 entries back-to-back → sum_ready drops after 4 accepted; 5th accepted the cycle after the first ack; no data loss or reorder.
- round=1, push idx 0,1,2 with data 0x8005, 7, 0x7FFF → writes to addr 8,9,10. With ACT_RELU_EN: data 0,7,0x7FFF; without it: 0x8005,7,0x7FFF. layer_done after the 3rd write.
- round=1, idx=3 (out of range), then round=2, idx=0 → both handshakes complete, no SRAM write, err=1 and stays 1 through later valid traffic until reset.
- Assert rst=0 while in WRITE with 3 entries queued → sram_we=0 immediately; after release FIFO empty, wr_count=0, no layer_done.
- Simultaneous accept and ack with FIFO at 3 entries → count stays 3, sum_ready stays 1, write order preserved.
